msg_buffer: RTL and testbench

Upstream feeder for the 7-digit effect display stage. Accepts a byte stream over a valid/ready handshake, assembles up to seven 7-bit character codes in a shadow buffer, and on end-of-message atomically publishes them on `char0`..`char6`. Command bytes in the same stream set the effect select (`enable`) and speed (`frequency`) consumed by the effect stages. The display never sees a half-written message.

---
 rtl/msg_buffer_pkg.sv | 24 ++
 rtl/msg_buffer_if.sv | 9 +
 rtl/msg_buffer_timer.sv | 27 ++
 rtl/msg_buffer.sv | 141 ++++++++++++++
 tb/tb_msg_buffer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_buffer_pkg.sv
// rtl/msg_buffer_pkg.sv - shared types and constants for the msg_buffer display feeder
package msg_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Command opcode lives in in_data[6:5] of a bit7=1 byte
  typedef enum logic [1:0] {
    CMD_EFFECT = 2'b00,
    CMD_FREQ   = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_t;

  localparam int         CHAR_COUNT = 7;
  localparam logic [6:0] CR_CODE    = 7'h0D;
  localparam logic [6:0] BLANK      = 7'h20;
  localparam logic [2:0] DEF_EFFECT = 3'b100;
  localparam logic [1:0] DEF_FREQ   = 2'b01;

endpackage

// File: rtl/msg_buffer_if.sv
// rtl/msg_buffer_if.sv - byte stream valid/ready handshake into msg_buffer
interface msg_buffer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/msg_buffer_timer.sv
// rtl/msg_buffer_timer.sv - msg_timeout_timer: idle counter that flags a stale pending message
module msg_timeout_timer #(
  parameter logic [27:0] TIMEOUT = 28'd50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expire
);

  logic [27:0] r_count;

  // Count idle cycles while running; any accepted byte or leaving FILL zeroes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 28'd0;
    end else if (restart || !run) begin
      r_count <= 28'd0;
    end else begin
      r_count <= r_count + 28'd1;
    end
  end

  assign expire = run && (r_count == (TIMEOUT - 28'd1));

endmodule

// File: rtl/msg_buffer.sv
// rtl/msg_buffer.sv - shadow-buffered 7-character message feeder; command decode under MSG_BUFFER_CMD_EN
module msg_buffer
  import msg_buffer_pkg::*;
#(
  parameter logic [27:0] TIMEOUT = 28'd50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  msg_buffer_if.slave  s,
  output logic [6:0]   char0,
  output logic [6:0]   char1,
  output logic [6:0]   char2,
  output logic [6:0]   char3,
  output logic [6:0]   char4,
  output logic [6:0]   char5,
  output logic [6:0]   char6,
  output logic [2:0]   enable,
  output logic [1:0]   frequency,
  output logic         commit_pulse,
  output logic         overflow
);

  state_t     r_state;
  logic [6:0] r_shadow [CHAR_COUNT];
  logic [6:0] r_char   [CHAR_COUNT];
  logic [2:0] r_wptr;
  logic       r_trunc;
  logic       r_commit_pulse;
  logic       r_overflow;

  logic w_accept;
  logic w_is_cmd;
  logic w_is_cr;
  logic w_is_char;
  logic w_clear;
  logic w_expire;

  assign s.in_ready = (r_state != COMMIT);
  assign w_accept   = s.in_valid && s.in_ready;
  assign w_is_cmd   = s.in_data[7];
  assign w_is_cr    = !w_is_cmd && (s.in_data[6:0] == CR_CODE);
  assign w_is_char  = !w_is_cmd && !w_is_cr;

`ifdef MSG_BUFFER_CMD_EN
  logic [2:0] r_enable;
  logic [1:0] r_freq;

  assign w_clear = w_is_cmd && (cmd_t'(s.in_data[6:5]) == CMD_CLEAR);

  // Effect/speed commands take effect at the accepting edge, independent of commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= DEF_EFFECT;
      r_freq   <= DEF_FREQ;
    end else if (w_accept && w_is_cmd) begin
      case (cmd_t'(s.in_data[6:5]))
        CMD_EFFECT: r_enable <= s.in_data[2:0];
        CMD_FREQ:   r_freq   <= s.in_data[1:0];
        default:    ;
      endcase
    end
  end

  assign enable    = r_enable;
  assign frequency = r_freq;
`else
  assign w_clear   = 1'b0;
  assign enable    = DEF_EFFECT;
  assign frequency = DEF_FREQ;
`endif

  msg_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (r_state == FILL),
    .restart (w_accept),
    .expire  (w_expire)
  );

  // Shadow storage needs no reset: slots at or beyond wptr are never published
  always_ff @(posedge clk) begin
    if (w_accept && w_is_char && (r_wptr < 3'd7)) begin
      r_shadow[r_wptr] <= s.in_data[6:0];
    end
  end

  // Message FSM: fill the shadow, then publish it atomically in the one-cycle COMMIT state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wptr         <= 3'd0;
      r_trunc        <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_overflow     <= 1'b0;
      for (int k = 0; k < CHAR_COUNT; k++) r_char[k] <= BLANK;
    end else begin
      r_commit_pulse <= 1'b0;
      case (r_state)
        IDLE, FILL: begin
          if (w_accept) begin
            if (w_is_char) begin
              if (r_wptr < 3'd7) r_wptr  <= r_wptr + 3'd1;
              else               r_trunc <= 1'b1;
              r_state <= FILL;
            end else if (w_is_cr) begin
              r_state <= COMMIT;
            end else if (w_clear) begin
              r_wptr  <= 3'd0;
              r_trunc <= 1'b0;
              r_state <= COMMIT;
            end
          end else if (w_expire) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          for (int k = 0; k < CHAR_COUNT; k++) begin
            r_char[k] <= (3'(k) < r_wptr) ? r_shadow[k] : BLANK;
          end
          r_overflow     <= r_trunc;
          r_commit_pulse <= 1'b1;
          r_wptr         <= 3'd0;
          r_trunc        <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign char0        = r_char[0];
  assign char1        = r_char[1];
  assign char2        = r_char[2];
  assign char3        = r_char[3];
  assign char4        = r_char[4];
  assign char5        = r_char[5];
  assign char6        = r_char[6];
  assign commit_pulse = r_commit_pulse;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_msg_buffer.sv
// tb/tb_msg_buffer.sv - scoreboard bench for msg_buffer
module tb_msg_buffer;
  import msg_buffer_pkg::*;

  typedef struct packed {
    logic            ovf;
    logic [6:0][6:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msg_buffer_if bus ();

  logic [6:0] c0, c1, c2, c3, c4, c5, c6;
  logic [2:0] enable;
  logic [1:0] frequency;
  logic       commit_pulse;
  logic       overflow;
  logic [6:0][6:0] dut_c;
  assign dut_c = {c6, c5, c4, c3, c2, c1, c0};

  msg_buffer #(.TIMEOUT(28'd100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (bus),
    .char0        (c0),
    .char1        (c1),
    .char2        (c2),
    .char3        (c3),
    .char4        (c4),
    .char5        (c5),
    .char6        (c6),
    .enable       (enable),
    .frequency    (frequency),
    .commit_pulse (commit_pulse),
    .overflow     (overflow)
  );

`ifdef MSG_BUFFER_CMD_EN
  localparam logic [2:0] EXP_EN_CMD   = 3'b011;
  localparam logic [1:0] EXP_FREQ_CMD = 2'b11;
`else
  localparam logic [2:0] EXP_EN_CMD   = 3'b100;
  localparam logic [1:0] EXP_FREQ_CMD = 2'b01;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string s, input logic ovf);
    exp_t e;
    byte  b;
    e.ovf = ovf;
    for (int k = 0; k < 7; k++) begin
      if (k < s.len()) begin
        b = s[k];
        e.c[k] = b[6:0];
      end else begin
        e.c[k] = BLANK;
      end
    end
    return e;
  endfunction

  task automatic check_chars(input string tag, input exp_t e);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s_char%0d", tag, k), 32'(dut_c[k]), 32'(e.c[k]));
    end
  endtask

  // Monitor: every commit pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && commit_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got commit_pulse=1 expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check_chars("commit", mon_e);
        check("commit_overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    last_stall = n;
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_commit(input int limit);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (!commit_pulse && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("commit_seen", 32'(commit_pulse), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_chars("rst", mk("", 1'b0));
    check("rst_enable", 32'(enable), 32'd4);
    check("rst_freq", 32'(frequency), 32'd1);
    check("rst_pulse", 32'(commit_pulse), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // HELLO + CR with commit timing
    exp_q.push_back(mk("HELLO", 1'b0));
    send_str("HELLO");
    send(8'h0D);
    check("commit_stall_ready", 32'(bus.in_ready), 32'd0);
    check("pulse_not_early", 32'(commit_pulse), 32'd0);
    idle(1);
    check("pulse_high", 32'(commit_pulse), 32'd1);
    check("ready_back", 32'(bus.in_ready), 32'd1);
    idle(1);
    check("pulse_fall", 32'(commit_pulse), 32'd0);

    // truncation then a short message clearing overflow
    exp_q.push_back(mk("ABCDEFG", 1'b1));
    send_str("ABCDEFGHI");
    send(8'h0D);
    wait_commit(5);
    exp_q.push_back(mk("X", 1'b0));
    send("X");
    send(8'h0D);
    wait_commit(5);

    // timeout: COMMIT entered 100 edges after the last byte
    exp_q.push_back(mk("AB", 1'b0));
    send_str("AB");
    idle(99);
    check("to_not_yet", 32'(bus.in_ready), 32'd1);
    idle(1);
    check("to_commit_state", 32'(bus.in_ready), 32'd0);
    idle(1);
    check("to_pulse", 32'(commit_pulse), 32'd1);

    // byte on the expiry cycle restarts the timer
    exp_q.push_back(mk("ABC", 1'b0));
    send_str("AB");
    idle(99);
    send("C");
    bus.in_valid = 1'b0;
    check("expiry_byte_wins", 32'(bus.in_ready), 32'd1);
    check("expiry_no_pulse", 32'(commit_pulse), 32'd0);
    idle(99);
    check("to2_not_yet", 32'(bus.in_ready), 32'd1);
    idle(1);
    check("to2_commit_state", 32'(bus.in_ready), 32'd0);
    idle(1);
    check("to2_pulse", 32'(commit_pulse), 32'd1);

    // effect and speed commands
    send(8'h83);
    check("cmd_enable", 32'(enable), 32'(EXP_EN_CMD));
    send(8'hA3);
    check("cmd_freq", 32'(frequency), 32'(EXP_FREQ_CMD));
    idle(3);
    check_chars("cmd_unchanged", mk("ABC", 1'b0));

    // reset mid-message
    send_str("AB");
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_enable", 32'(enable), 32'd4);
    check("mid_rst_freq", 32'(frequency), 32'd1);
    check_chars("mid_rst", mk("", 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk("", 1'b0));
    send(8'h0D);
    wait_commit(5);
    check("post_rst_enable", 32'(enable), 32'd4);
    check("post_rst_freq", 32'(frequency), 32'd1);

    // valid held across a commit: exactly one stall, nothing lost or duplicated
    exp_q.push_back(mk("HI", 1'b0));
    exp_q.push_back(mk("Z", 1'b0));
    send("H");
    send("I");
    send(8'h0D);
    send("Z");
    check("held_stall", 32'(last_stall), 32'd1);
    send(8'h0D);
    wait_commit(5);

    // clear command
`ifdef MSG_BUFFER_CMD_EN
    exp_q.push_back(mk("", 1'b0));
    exp_q.push_back(mk("", 1'b0));
    send_str("QR");
    send(8'hC0);
    wait_commit(5);
    send(8'h0D);
    wait_commit(5);
`else
    exp_q.push_back(mk("QR", 1'b0));
    send_str("QR");
    send(8'hC0);
    send(8'h0D);
    wait_commit(5);
`endif

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
